alu_trace_fifo: RTL and testbench

ALU_TRACE_FIFO -- requirements
Module: alu_trace_fifo

---
 rtl/alu_trace_fifo.sv | 72 +++++++
 tb/tb_alu_trace_fifo.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_trace_fifo.sv
// alu_trace_fifo: first-word-fall-through trace FIFO of {flags, alu_out} captures with sticky overflow.
// Define ALU_TRACE_DROP_COUNT_EN to add the saturating 8-bit drop_count output.
module alu_trace_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [15:0]              alu_out,
    input  logic [4:0]               flags,
    input  logic                     capture_en,
    input  logic                     clear,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [20:0]              rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow
`ifdef ALU_TRACE_DROP_COUNT_EN
    ,
    output logic [7:0]               drop_count
`endif
);
    localparam int AW = $clog2(DEPTH);
    logic [20:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d, pop, push, drop;
    always_comb begin
        empty      = count_q == '0;
        full       = count_q == (AW+1)'(DEPTH);
        pop        = !empty && rd_ready;
        push       = capture_en && (!full || pop);
        drop       = capture_en && full && !pop;
        wr_ptr_d   = clear ? '0 : wr_ptr_q + AW'(push);
        rd_ptr_d   = clear ? '0 : rd_ptr_q + AW'(pop);
        count_d    = clear ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
        overflow_d = !clear && (overflow_q || drop);
        rd_valid   = !empty;
        rd_data    = empty ? '0 : mem_q[rd_ptr_q];
        count      = count_q;
        overflow   = overflow_q;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end
    // Storage is not reset; an empty count masks whatever it holds.
    always_ff @(posedge clk) begin
        if (push && !clear) mem_q[wr_ptr_q] <= {flags, alu_out};
    end
`ifdef ALU_TRACE_DROP_COUNT_EN
    logic [7:0] drop_count_q, drop_count_d;
    always_comb begin
        drop_count_d = clear ? 8'h00 : (drop && drop_count_q != 8'hFF) ? drop_count_q + 8'h01 : drop_count_q;
        drop_count   = drop_count_q;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) drop_count_q <= 8'h00;
        else drop_count_q <= drop_count_d;
    end
`endif
endmodule

// File: tb/tb_alu_trace_fifo.sv
// tb_alu_trace_fifo: scenario tasks plus randomized traffic checked against a queue-based model.
module tb_alu_trace_fifo;
    localparam int DEPTH = 8;
    localparam int CW = $clog2(DEPTH) + 1;
    logic          clk = 1'b0, reset = 1'b1;
    logic [15:0]   alu_out = '0;
    logic [4:0]    flags = '0;
    logic          capture_en = 1'b0, clear = 1'b0, rd_ready = 1'b0;
    logic          rd_valid, full, empty, overflow;
    logic [20:0]   rd_data;
    logic [CW-1:0] count;
    logic [CW+24:0] obs;
    logic [20:0]   mq[$];
    bit            m_ovf;
    int            m_dc;
    int            vectors = 0, errors = 0;
`ifdef ALU_TRACE_DROP_COUNT_EN
    logic [7:0]    drop_count;
`endif

    alu_trace_fifo #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .alu_out(alu_out), .flags(flags),
        .capture_en(capture_en), .clear(clear), .rd_ready(rd_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .count(count),
        .full(full), .empty(empty), .overflow(overflow)
`ifdef ALU_TRACE_DROP_COUNT_EN
        , .drop_count(drop_count)
`endif
    );

    always #5 clk = ~clk;
    assign obs = {rd_valid, rd_data, count, full, empty, overflow};

    function automatic logic [CW+24:0] exp_vec();
        logic [20:0] h;
        h = mq.size() != 0 ? mq[0] : 21'h0;
        return {mq.size() != 0, h, CW'(mq.size()), mq.size() == DEPTH, mq.size() == 0, m_ovf};
    endfunction

    // Advances the model with the inputs currently applied, then the DUT by one edge.
    task automatic tick();
        bit p, f;
        p = mq.size() != 0 && rd_ready;
        f = mq.size() == DEPTH;
        if (clear) begin
            mq.delete();
            m_ovf = 0;
            m_dc = 0;
        end else begin
            if (p) void'(mq.pop_front());
            if (capture_en) begin
                if (!f || p) mq.push_back({flags, alu_out});
                else begin
                    m_ovf = 1;
                    if (m_dc != 255) m_dc++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        vectors++;
        if (obs !== exp_vec()) begin errors++; $display("FAIL reset_state obs=%h exp=%h", obs, exp_vec()); end
        #2 reset = 1'b0;
    endtask

    task automatic test_first_capture();
        capture_en = 1; alu_out = 16'h0001; flags = 5'h00; rd_ready = 0;
        tick();
        capture_en = 0;
        vectors++;
        if (rd_valid !== 1'b1 || rd_data !== 21'h000001 || count !== CW'(1)) begin
            errors++; $display("FAIL first_capture valid=%b data=%h count=%0d exp 1/000001/1", rd_valid, rd_data, count);
        end
        rd_ready = 1;
        tick();
        rd_ready = 0;
        vectors++;
        if (obs !== exp_vec()) begin errors++; $display("FAIL first_drain obs=%h exp=%h", obs, exp_vec()); end
    endtask

    task automatic test_fibonacci();
        int fib[8] = '{1, 1, 2, 3, 5, 8, 13, 21};
        flags = 0;
        for (int i = 0; i < 8; i++) begin
            capture_en = 1; alu_out = 16'(fib[i]);
            tick();
        end
        capture_en = 0;
        vectors++;
        if (full !== 1'b1 || count !== CW'(8)) begin errors++; $display("FAIL fib_full full=%b count=%0d exp 1/8", full, count); end
        rd_ready = 1;
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (rd_data !== 21'(fib[i])) begin errors++; $display("FAIL fib_read[%0d] got=%h exp=%h", i, rd_data, 21'(fib[i])); end
            tick();
        end
        rd_ready = 0;
        vectors++;
        if (empty !== 1'b1 || obs !== exp_vec()) begin errors++; $display("FAIL fib_empty obs=%h exp=%h", obs, exp_vec()); end
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) begin
            capture_en = 1; alu_out = 16'($urandom); flags = 5'($urandom);
            tick();
        end
        capture_en = 0;
    endtask

    task automatic test_overflow();
        fill(8);
        capture_en = 1; alu_out = 16'h0022; flags = 0; rd_ready = 0;
        tick();
        vectors++;
        if (overflow !== 1'b1 || obs !== exp_vec()) begin errors++; $display("FAIL ovf_first obs=%h exp=%h", obs, exp_vec()); end
`ifdef ALU_TRACE_DROP_COUNT_EN
        vectors++;
        if (drop_count !== 8'd1) begin errors++; $display("FAIL drop_count_1 got=%0d exp=1", drop_count); end
`endif
        for (int i = 0; i < 299; i++) begin
            alu_out = 16'($urandom);
            tick();
        end
        capture_en = 0;
`ifdef ALU_TRACE_DROP_COUNT_EN
        vectors++;
        if (drop_count !== 8'(m_dc)) begin errors++; $display("FAIL drop_count_sat got=%0d exp=%0d", drop_count, m_dc); end
`endif
        rd_ready = 1;
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL ovf_drain[%0d] obs=%h exp=%h", i, obs, exp_vec()); end
            tick();
        end
        rd_ready = 0; clear = 1;
        tick();
        clear = 0;
        vectors++;
        if (overflow !== 1'b0 || obs !== exp_vec()) begin errors++; $display("FAIL ovf_clear obs=%h exp=%h", obs, exp_vec()); end
    endtask

    task automatic test_full_pop_write();
        fill(8);
        capture_en = 1; alu_out = 16'h0022; flags = 0; rd_ready = 1;
        tick();
        capture_en = 0;
        vectors++;
        if (count !== CW'(8) || overflow !== 1'b0) begin errors++; $display("FAIL full_pop_write count=%0d ovf=%b exp 8/0", count, overflow); end
        for (int i = 0; i < 7; i++) begin
            vectors++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL fpw_drain[%0d] obs=%h exp=%h", i, obs, exp_vec()); end
            tick();
        end
        vectors++;
        if (rd_data !== 21'h000022 || count !== CW'(1)) begin errors++; $display("FAIL fpw_tail got=%h count=%0d exp 000022/1", rd_data, count); end
        tick();
        rd_ready = 0;
    endtask

    task automatic test_clear();
        fill(5);
        clear = 1; capture_en = 1; rd_ready = 1; alu_out = 16'h1234;
        tick();
        clear = 0; capture_en = 0; rd_ready = 0;
        vectors++;
        if (count !== '0 || empty !== 1'b1 || overflow !== 1'b0 || obs !== exp_vec()) begin
            errors++; $display("FAIL clear_prio obs=%h exp=%h", obs, exp_vec());
        end
        tick();
        vectors++;
        if (rd_valid !== 1'b0) begin errors++; $display("FAIL clear_nowrite valid=%b exp 0", rd_valid); end
    endtask

    task automatic test_async_reset();
        fill(3);
        #2 reset = 1;
        mq.delete(); m_ovf = 0; m_dc = 0;
        #1;
        vectors++;
        if (obs !== exp_vec()) begin errors++; $display("FAIL async_reset obs=%h exp=%h", obs, exp_vec()); end
        #2 reset = 0;
        capture_en = 1; alu_out = 16'h0037; flags = 0;
        tick();
        capture_en = 0;
        vectors++;
        if (rd_data !== 21'h000037 || count !== CW'(1)) begin errors++; $display("FAIL post_reset got=%h count=%0d exp 000037/1", rd_data, count); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            capture_en = 1'($urandom_range(0, 99) < 60);
            rd_ready = 1'($urandom_range(0, 99) < 45);
            clear = 1'($urandom_range(0, 99) < 3);
            alu_out = 16'($urandom); flags = 5'($urandom);
            tick();
            vectors++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL random[%0d] obs=%h exp=%h", i, obs, exp_vec()); end
`ifdef ALU_TRACE_DROP_COUNT_EN
            vectors++;
            if (drop_count !== 8'(m_dc)) begin errors++; $display("FAIL random_dc[%0d] got=%0d exp=%0d", i, drop_count, m_dc); end
`endif
        end
        capture_en = 0; rd_ready = 0; clear = 0;
    endtask

    initial begin
        test_reset();
        test_first_capture();
        test_fibonacci();
        test_overflow();
        test_full_pop_write();
        test_clear();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
